// File: rtl/apb_gpio_slave.sv
// APB completer for a 4-word GPIO register bank (CTRL, DATA, MASK, STATUS); PREADY after WAIT_STATES+1 ACCESS cycles.
// Byte-strobed writes. PSLVERR flags misaligned accesses and writes to the read-only STATUS word.
module apb_gpio_slave #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4,
  parameter int STRB_WIDTH    = 4,
  parameter int WAIT_STATES   = 0
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [ADDRESS_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0]    PWDATA,
  input  logic [STRB_WIDTH-1:0]    PSTRB,
  output logic [DATA_WIDTH-1:0]    PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  input  logic [DATA_WIDTH-1:0]    GPIO_IN,
  output logic [DATA_WIDTH-1:0]    GPIO_OUT
);

  localparam int CW = 4;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [1:0]              idx_q, idx_d;
  logic                    write_q, write_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   strb_q, strb_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0]   ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   mask_q, mask_d;
  logic [DATA_WIDTH-1:0]   gpio_out_q, gpio_out_d;

  logic                    setup;
  logic                    setup_err;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   rd_mux;
  logic [DATA_WIDTH-1:0]   wr_target;
  logic [DATA_WIDTH-1:0]   wr_merged;

  assign setup     = PSEL & ~PENABLE;
  assign setup_err = (PADDR[1:0] != 2'b00) | (PWRITE & (PADDR[3:2] == 2'd3));
  assign ready     = (state_q == ACCESS) && (cnt_q == '0);

  always_comb begin
    rd_mux = '0;
    case (PADDR[3:2])
      2'd0:    rd_mux = ctrl_q;
      2'd1:    rd_mux = data_q;
      2'd2:    rd_mux = mask_q;
      default: rd_mux = GPIO_IN;
    endcase
  end

  // Merge the latched write data into the addressed register, lane by lane.
  always_comb begin
    wr_target = '0;
    case (idx_q)
      2'd0:    wr_target = ctrl_q;
      2'd1:    wr_target = data_q;
      2'd2:    wr_target = mask_q;
      default: wr_target = '0;
    endcase
    wr_merged = wr_target;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (strb_q[i]) begin
        wr_merged[8*i +: 8] = wdata_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    err_d      = err_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    prdata_d   = prdata_q;
    ctrl_d     = ctrl_q;
    data_d     = data_q;
    mask_d     = mask_q;
    gpio_out_d = data_q & mask_q;

    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = ACCESS;
          cnt_d   = CW'(WAIT_STATES);
          idx_d   = PADDR[3:2];
          write_d = PWRITE;
          err_d   = setup_err;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          if (!PWRITE) begin
            prdata_d = setup_err ? '0 : rd_mux;
          end
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (PENABLE) begin
          state_d = IDLE;
          if (write_q && !err_q) begin
            case (idx_q)
              2'd0:    ctrl_d = wr_merged;
              2'd1:    data_d = wr_merged;
              2'd2:    mask_d = wr_merged;
              default: ;
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      prdata_q   <= '0;
      ctrl_q     <= '0;
      data_q     <= '0;
      mask_q     <= '1;
      gpio_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      err_q      <= err_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      prdata_q   <= prdata_d;
      ctrl_q     <= ctrl_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      gpio_out_q <= gpio_out_d;
    end
  end

  assign PRDATA   = prdata_q;
  assign PREADY   = ready;
  assign PSLVERR  = ready & err_q;
  assign GPIO_OUT = gpio_out_q;

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Directed bench: instance 0 has no wait states, instance 1 has two; both share the APB bus and GPIO_IN.
module tb_apb_gpio_slave;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int SW = 4;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic [1:0]    psel;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [DW-1:0] GPIO_IN;

  logic [DW-1:0] prdata   [2];
  logic          pready   [2];
  logic          pslverr  [2];
  logic [DW-1:0] gpio_out [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 PCLK = ~PCLK;

  apb_gpio_slave #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STRB_WIDTH(SW), .WAIT_STATES(0)) u_dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .GPIO_IN(GPIO_IN), .GPIO_OUT(gpio_out[0])
  );

  apb_gpio_slave #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STRB_WIDTH(SW), .WAIT_STATES(2)) u_dut1 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .GPIO_IN(GPIO_IN), .GPIO_OUT(gpio_out[1])
  );

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Starts at #1 after an edge, ends at #1 after the completion edge with the bus idle.
  task automatic apb_xfer(input int d, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                          output logic [DW-1:0] rdata, output logic err, output int waits);
    psel    = 2'b00;
    psel[d] = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = wdata;
    PSTRB   = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits   = 0;
    while (!pready[d] && waits < 40) begin
      @(posedge PCLK); #1;
      waits++;
    end
    if (!pready[d]) check("pready_timeout", DW'(pready[d]), 32'h1);
    err   = pslverr[d];
    rdata = prdata[d];
    @(posedge PCLK); #1;
    psel    = 2'b00;
    PENABLE = 1'b0;
  endtask

  task automatic do_wr(input string tag, input int d, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                       input logic exp_err, input int exp_waits);
    logic [DW-1:0] rd;
    logic          err;
    int            waits;
    apb_xfer(d, 1'b1, addr, wdata, strb, rd, err, waits);
    check({tag, "_err"}, DW'(err), DW'(exp_err));
    check({tag, "_waits"}, waits, exp_waits);
  endtask

  task automatic do_rd(input string tag, input int d, input logic [AW-1:0] addr,
                       input logic [DW-1:0] exp_data, input logic exp_err, input int exp_waits);
    logic [DW-1:0] rd;
    logic          err;
    int            waits;
    apb_xfer(d, 1'b0, addr, 32'h0, 4'hF, rd, err, waits);
    check({tag, "_data"}, rd, exp_data);
    check({tag, "_err"}, DW'(err), DW'(exp_err));
    check({tag, "_waits"}, waits, exp_waits);
    check({tag, "_err_idle"}, DW'(pslverr[d]), 32'h0);
  endtask

  initial begin
    PRESET  = 1'b1;
    psel    = 2'b00;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    PSTRB   = '0;
    GPIO_IN = '0;
    repeat (3) @(posedge PCLK);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_prdata", prdata[d], 32'h0);
      check("rst_pready", DW'(pready[d]), 32'h0);
      check("rst_pslverr", DW'(pslverr[d]), 32'h0);
      check("rst_gpio", gpio_out[d], 32'h0);
    end
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    // Reset value of MASK, zero-wait transfer.
    do_rd("t1_mask", 0, 4'h8, 32'hFFFF_FFFF, 1'b0, 0);
    check("t1_gpio", gpio_out[0], 32'h0);

    // GPIO_OUT follows one edge after the DATA write commits.
    do_wr("t2_data", 0, 4'h4, 32'h0000_00F0, 4'hF, 1'b0, 0);
    check("t2_gpio_same", gpio_out[0], 32'h0);
    @(posedge PCLK); #1;
    check("t2_gpio_next", gpio_out[0], 32'h0000_00F0);

    // Single-lane MASK write clears bits 7:4 of byte 0 only.
    do_wr("t3_mask", 0, 4'h8, 32'h0000_000F, 4'b0001, 1'b0, 0);
    @(posedge PCLK); #1;
    check("t3_gpio", gpio_out[0], 32'h0);
    do_rd("t3_mask_rd", 0, 4'h8, 32'hFFFF_FF0F, 1'b0, 0);
    do_rd("t3_data_rd", 0, 4'h4, 32'h0000_00F0, 1'b0, 0);
    do_wr("t3_ctrl", 0, 4'h0, 32'h1234_5678, 4'b1010, 1'b0, 0);
    do_rd("t3_ctrl_rd", 0, 4'h0, 32'h1200_5600, 1'b0, 0);

    // Two wait states on instance 1.
    GPIO_IN = 32'hA5A5_A5A5;
    do_rd("t4_status", 1, 4'hC, 32'hA5A5_A5A5, 1'b0, 2);
    do_wr("t4_data", 1, 4'h4, 32'h0000_00AA, 4'hF, 1'b0, 2);
    @(posedge PCLK); #1;
    check("t4_gpio", gpio_out[1], 32'h0000_00AA);

    // Error cases leave the registers untouched.
    do_wr("t5_wr_status", 0, 4'hC, 32'hDEAD_BEEF, 4'hF, 1'b1, 0);
    do_wr("t5_wr_misal", 0, 4'h5, 32'hFFFF_FFFF, 4'hF, 1'b1, 0);
    do_rd("t5_rd_misal", 0, 4'h2, 32'h0, 1'b1, 0);
    do_rd("t5_data_rd", 0, 4'h4, 32'h0000_00F0, 1'b0, 0);
    do_rd("t5_mask_rd", 0, 4'h8, 32'hFFFF_FF0F, 1'b0, 0);
    do_rd("t5_ctrl_rd", 0, 4'h0, 32'h1200_5600, 1'b0, 0);
    do_wr("t5_nostrb", 0, 4'h4, 32'hFFFF_FFFF, 4'h0, 1'b0, 0);
    do_rd("t5_nostrb_rd", 0, 4'h4, 32'h0000_00F0, 1'b0, 0);

    // Aborted write: PSEL drops during ACCESS.
    psel[1] = 1'b1; PWRITE = 1'b1; PADDR = 4'h4; PWDATA = 32'h11; PSTRB = 4'hF; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    psel = 2'b00;
    check("abort_pready", DW'(pready[1]), 32'h0);
    @(posedge PCLK); #1;
    do_rd("abort_rd", 1, 4'h4, 32'h0000_00AA, 1'b0, 2);

    // PENABLE without a setup phase is ignored.
    psel[1] = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 4'h8;
    @(posedge PCLK); #1;
    check("noset_pready0", DW'(pready[1]), 32'h0);
    @(posedge PCLK); #1;
    check("noset_pready1", DW'(pready[1]), 32'h0);
    psel = 2'b00; PENABLE = 1'b0;
    @(posedge PCLK); #1;

    // Reset during ACCESS of a DATA write.
    psel[1] = 1'b1; PWRITE = 1'b1; PADDR = 4'h4; PWDATA = 32'h55; PSTRB = 4'hF; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2 PRESET = 1'b1;
    #1;
    check("t6_pready", DW'(pready[1]), 32'h0);
    check("t6_gpio", gpio_out[1], 32'h0);
    psel = 2'b00; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    do_rd("t6_data_rd", 1, 4'h4, 32'h0, 1'b0, 2);
    do_rd("t6_mask_rd", 1, 4'h8, 32'hFFFF_FFFF, 1'b0, 2);
    do_rd("t6_dut0_data", 0, 4'h4, 32'h0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
